// File: rtl/and_reduce_ctrl.sv
// Multi-cycle AND reduction of an N-bit operand, W bits per cycle, with
// early exit on the first chunk containing a zero and a valid/ready handshake.
module and_reduce_ctrl #(
  parameter int N = 8,
  parameter int W = 2,
  localparam int C  = N / W,
  localparam int CW = $clog2(C + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:N-1]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          y,
  output logic [CW-1:0] chunks
);

  localparam int IW = (C > 1) ? $clog2(C) : 1;

  generate
    if (N < 1 || W < 1 || W > N || (N % W) != 0) begin : g_param_err
      $error("and_reduce_ctrl: need N >= 1, 1 <= W <= N and N divisible by W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [0:N-1]  op_reg, op_next;
  logic          acc_reg, acc_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          y_reg, y_next;
  logic [CW-1:0] chunks_reg, chunks_next;

  // Per-chunk AND of the captured operand; the FSM selects one per cycle.
  logic [C-1:0]  chunk_and;
  logic          cur_and;
  logic          last_chunk;

  genvar gi;
  generate
    for (gi = 0; gi < C; gi++) begin : g_chunk
      assign chunk_and[gi] = &op_reg[gi*W +: W];
    end
  endgenerate

  assign cur_and    = chunk_and[idx_reg];
  assign last_chunk = (idx_reg == IW'(C - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      acc_reg    <= 1'b1;
      idx_reg    <= '0;
      y_reg      <= 1'b0;
      chunks_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      acc_reg    <= acc_next;
      idx_reg    <= idx_next;
      y_reg      <= y_next;
      chunks_reg <= chunks_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    acc_next    = acc_reg;
    idx_next    = idx_reg;
    y_next      = y_reg;
    chunks_next = chunks_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next    = x;
          acc_next   = 1'b1;
          idx_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = acc_reg & cur_and;
        // idx holds on exit so it never steps past the last chunk.
        if (!cur_and) begin
          y_next      = 1'b0;
          chunks_next = CW'(idx_reg) + CW'(1);
          state_next  = DONE;
        end else if (last_chunk) begin
          y_next      = acc_next;
          chunks_next = CW'(C);
          state_next  = DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign y         = y_reg;
  assign chunks    = chunks_reg;

endmodule

// File: doc/and_reduce_ctrl.md
AND_REDUCE_CTRL -- requirements
Module: and_reduce_ctrl

Interface
REQ-001 Parameter N, default 8: operand width in bits; SHALL be >= 1.
REQ-002 Parameter W, default 2: bits reduced per cycle; SHALL satisfy 1 <= W <= N and N % W == 0; violation SHALL be a compile-time error.
REQ-003 Derived C = N/W (chunk count) and CW = $clog2(C+1) (count width); both local, not overridable.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 x  input  [0:N-1]  operand; x[0] is the first bit reduced.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 y  output  1  AND of all N bits of the accepted operand.
REQ-012 chunks  output  CW  number of chunks evaluated to produce y (1..C).

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, encoded as a registered state variable.
REQ-014 in_ready SHALL be 1 exactly in IDLE; out_valid SHALL be 1 exactly in DONE; both SHALL be decoded from registered state only.
REQ-015 IDLE with in_valid=1 at an edge: capture x into an N-bit operand register, set acc=1 and idx=0, then go to RUN; in_valid=0 stays in IDLE.
REQ-016 In RUN, chunk k SHALL be x[k*W .. k*W+W-1] of the captured operand; each cycle, acc <= acc & (AND of chunk idx) and idx <= idx+1.
REQ-017 RUN exit: if chunk idx contains any 0, go to DONE with y=0 and chunks=idx+1 (early termination); else if idx==C-1, go to DONE with y=1 and chunks=C; otherwise stay in RUN.
REQ-018 Latency from the accept edge to out_valid=1 SHALL equal the chunks value in cycles: C cycles for an all-ones operand, k+1 cycles when the first zero lies in chunk k.
REQ-019 DONE SHALL hold y and chunks stable while out_valid=1 and out_ready=0; out_ready=1 at an edge returns to IDLE.
REQ-020 No new operand SHALL be accepted in RUN or DONE; accept-to-accept throughput is at most one operand per chunks+2 cycles.
REQ-021 Changes on x or in_valid after capture SHALL NOT affect the result in flight.
REQ-022 For N==W, RUN SHALL last exactly one cycle, and chunks SHALL be 1.
REQ-023 y and chunks SHALL be registered; their values outside DONE are don't-care but SHALL NOT be X after reset.
REQ-024 idx SHALL never exceed C-1; no wrap-around is permitted.

Reset
REQ-025 When rst=1, state SHALL be IDLE, with acc=1, idx=0, y=0, chunks=0, out_valid=0 and in_ready=1; no operand SHALL be captured while rst=1.
REQ-026 Reset asserted in RUN or DONE SHALL abort immediately and discard the result; the first accept after rst deasserts SHALL behave as from power-up.

Verification
REQ-027 N=8, W=2, x=8'b1111_1111, out_ready held 1: out_valid rises 4 cycles after the accept edge with y=1 and chunks=4; in_ready returns 1 the next cycle.
REQ-028 N=8, W=2, x[0]=0 and all other bits 1: out_valid after 1 cycle with y=0 and chunks=1; x[7]=0 only: 4 cycles, y=0, chunks=4.
REQ-029 Backpressure, with out_ready=0 for 5 cycles in DONE: y and chunks remain stable and in_valid=1 with new x is ignored (in_ready=0); the result is consumed on the first out_ready=1 edge.
REQ-030 rst pulsed during cycle 2 of RUN: out_valid never asserts for that operand, in_ready=1 while rst=1, and the next operand x=8'hFF yields y=1 and chunks=4.
REQ-031 N=W=1: x=1 gives y=1 and chunks=1 after 1 cycle; x=0 gives y=0; x is changed after the accept edge with no effect.
REQ-032 Random back-to-back operands (N=8 with W in {1,2,4,8}) with random in_valid/out_ready: y equals the AND reduction of x and chunks equals the index of the first chunk containing a 0, plus 1, else C, for every transaction.
